dma_burst_ctrl: RTL and testbench

Parametrised DMA engine between the byte-wide command/UART path and the wide DDR user port. Write commands pack an incoming byte stream into DDR_W-bit words and burst them to consecutive DDR addresses. Read commands fetch words and unpack them to a byte stream, for example toward the ICAP loader. It adds programmable word width, auto-incrementing addresses, partial-word tails, byte-stream backpressure and abort, none of which the first-generation controller has.

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_byte_unpack.sv | 25 ++
 rtl/dma_burst_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dma_burst_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA burst controller: FSM states, default
// word geometry and the tail-length helper used when a word is retired.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WR_REQ,
    S_RD_REQ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int DDR_W_DEF  = 512;
  localparam int BPW_DEF    = DDR_W_DEF / 8;
  localparam int LANE_W_DEF = $clog2(BPW_DEF);

  // Bytes actually carried by the word being retired: never more than remain.
  function automatic int unsigned bytes_in_word(input int unsigned rem,
                                                input int unsigned lane);
    return (rem < lane) ? rem : lane;
  endfunction

endpackage

// File: rtl/dma_byte_unpack.sv
// Holds one DDR read word and presents the byte selected by the drain lane.
module dma_byte_unpack #(
  parameter int DDR_W = 512
) (
  input  logic                          i_clk,
  input  logic                          reset,
  input  logic                          cap_i,
  input  logic [DDR_W-1:0]              word_i,
  input  logic [$clog2(DDR_W/8)-1:0]    lane_i,
  output logic [7:0]                    byte_o
);

  logic [DDR_W-1:0] word_q;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      word_q <= '0;
    end else if (cap_i) begin
      word_q <= word_i;
    end
  end

  assign byte_o = word_q[{lane_i, 3'b000} +: 8];

endmodule

// File: rtl/dma_burst_ctrl.sv
// Byte-stream <-> DDR word DMA engine: packs write bytes into words, unpacks
// read words into bytes, with auto-incrementing word addresses and abort.
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int DDR_W  = DDR_W_DEF,
  parameter int ADDR_W = 27,
  parameter int LEN_W  = 20
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_abort,
  input  logic [7:0]        i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [7:0]        o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [ADDR_W-1:0] o_ddr_addr,
  output logic [DDR_W-1:0]  o_ddr_data,
  output logic              o_ddr_wr,
  input  logic              i_ddr_wr_done,
  output logic              o_ddr_rd,
  input  logic              i_ddr_rd_done,
  input  logic [DDR_W-1:0]  i_ddr_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  localparam int BPW    = DDR_W / 8;
  localparam int LANE_W = $clog2(BPW);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LANE_W:0]     lane_q, lane_d;   // one extra bit so a full word counts to BPW
  logic [DDR_W-1:0]    word_q, word_d;
  logic                aborted_q, aborted_d;
  logic                cap;
  logic                lane_last;
  logic                fill_end;
  logic                run;
  logic [7:0]          rd_byte;

  assign lane_last = (lane_q == (LANE_W+1)'(BPW-1));
  assign fill_end  = (rem_q == LEN_W'(lane_q) + LEN_W'(1));

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    lane_d    = lane_q;
    word_d    = word_q;
    aborted_d = 1'b0;
    cap       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          addr_d = i_cmd_addr & ~ADDR_W'(BPW-1);
          rem_d  = i_cmd_len;
          lane_d = '0;
          word_d = '0;
          if (i_cmd_len == '0)   state_d = S_DONE;
          else if (i_cmd_write)  state_d = S_FILL;
          else                   state_d = S_RD_REQ;
        end
      end
      S_FILL: begin
        if (i_data_valid) begin
          word_d[{lane_q[LANE_W-1:0], 3'b000} +: 8] = i_data;
          lane_d = lane_q + 1'b1;
          if (lane_last || fill_end) state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (i_ddr_wr_done) begin
          addr_d  = addr_q + ADDR_W'(BPW);
          rem_d   = rem_q - LEN_W'(bytes_in_word(32'(rem_q), 32'(lane_q)));
          lane_d  = '0;
          word_d  = '0;
          state_d = (rem_d == '0) ? S_DONE : S_FILL;
        end
      end
      S_RD_REQ: begin
        if (i_ddr_rd_done) begin
          cap     = 1'b1;
          lane_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_rd_ready) begin
          lane_d = lane_q + 1'b1;
          rem_d  = (rem_q == '0) ? '0 : rem_q - LEN_W'(1);
          if (lane_last || rem_q <= LEN_W'(1)) begin
            addr_d  = addr_q + ADDR_W'(BPW);
            state_d = (rem_d == '0) ? S_DONE : S_RD_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort freezes the datapath so a coincident DDR done leaves no trace.
    if (i_abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      addr_d    = addr_q;
      rem_d     = rem_q;
      lane_d    = lane_q;
      word_d    = word_q;
      cap       = 1'b0;
      aborted_d = 1'b1;
    end
  end

  dma_byte_unpack #(.DDR_W(DDR_W)) u_unpack (
    .i_clk  (i_clk),
    .reset  (reset),
    .cap_i  (cap),
    .word_i (i_ddr_rd_data),
    .lane_i (lane_q[LANE_W-1:0]),
    .byte_o (rd_byte)
  );

  // Everything is forced low while reset is held, even before the first edge.
  assign run          = !reset;
  assign o_cmd_ready  = run && (state_q == S_IDLE);
  assign o_busy       = run && (state_q != S_IDLE);
  assign o_data_ready = run && (state_q == S_FILL);
  assign o_ddr_wr     = run && (state_q == S_WR_REQ);
  assign o_ddr_rd     = run && (state_q == S_RD_REQ);
  assign o_rd_valid   = run && (state_q == S_DRAIN);
  assign o_done       = run && (state_q == S_DONE);
  assign o_aborted    = run && aborted_q;
  assign o_ddr_addr   = run ? addr_q : '0;
  assign o_ddr_data   = run ? word_q : '0;
  assign o_rd_data    = run ? rd_byte : 8'h00;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Randomised scoreboard bench for dma_burst_ctrl at DDR_W=512 and DDR_W=64.
module tb_dma_burst_ctrl;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic         reset, i_cmd_valid, i_cmd_write, i_abort, i_data_valid;
  logic         i_rd_ready, i_ddr_wr_done, i_ddr_rd_done;
  logic [26:0]  i_cmd_addr;
  logic [19:0]  i_cmd_len;
  logic [7:0]   i_data;
  logic [511:0] i_ddr_rd_data;

  logic         b_cmd_ready, b_data_ready, b_rd_valid, b_ddr_wr, b_ddr_rd, b_busy, b_done, b_aborted;
  logic [7:0]   b_rd_data;
  logic [26:0]  b_ddr_addr;
  logic [511:0] b_ddr_data;
  logic         m_cmd_ready, m_data_ready, m_rd_valid, m_ddr_wr, m_ddr_rd, m_busy, m_done, m_aborted;
  logic [7:0]   m_rd_data;
  logic [26:0]  m_ddr_addr;
  logic [63:0]  m_ddr_data;

  bit           sel;  // 0: 512-bit instance, 1: 64-bit instance
  logic         s_cmd_ready, s_data_ready, s_rd_valid, s_ddr_wr, s_ddr_rd, s_busy, s_done, s_aborted;
  logic [7:0]   s_rd_data;
  logic [26:0]  s_ddr_addr;
  logic [511:0] s_ddr_data;

  dma_burst_ctrl #(.DDR_W(512), .ADDR_W(27), .LEN_W(20)) u_big (
    .i_clk(i_clk), .reset(reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(b_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .i_abort(i_abort),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(b_data_ready),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .i_rd_ready(i_rd_ready),
    .o_ddr_addr(b_ddr_addr), .o_ddr_data(b_ddr_data), .o_ddr_wr(b_ddr_wr), .i_ddr_wr_done(i_ddr_wr_done),
    .o_ddr_rd(b_ddr_rd), .i_ddr_rd_done(i_ddr_rd_done), .i_ddr_rd_data(i_ddr_rd_data),
    .o_busy(b_busy), .o_done(b_done), .o_aborted(b_aborted));

  dma_burst_ctrl #(.DDR_W(64), .ADDR_W(27), .LEN_W(20)) u_small (
    .i_clk(i_clk), .reset(reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(m_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .i_abort(i_abort),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(m_data_ready),
    .o_rd_data(m_rd_data), .o_rd_valid(m_rd_valid), .i_rd_ready(i_rd_ready),
    .o_ddr_addr(m_ddr_addr), .o_ddr_data(m_ddr_data), .o_ddr_wr(m_ddr_wr), .i_ddr_wr_done(i_ddr_wr_done),
    .o_ddr_rd(m_ddr_rd), .i_ddr_rd_done(i_ddr_rd_done), .i_ddr_rd_data(i_ddr_rd_data[63:0]),
    .o_busy(m_busy), .o_done(m_done), .o_aborted(m_aborted));

  always_comb begin
    {s_cmd_ready, s_data_ready, s_rd_valid, s_ddr_wr, s_ddr_rd, s_busy, s_done, s_aborted} =
      {b_cmd_ready, b_data_ready, b_rd_valid, b_ddr_wr, b_ddr_rd, b_busy, b_done, b_aborted};
    s_rd_data  = b_rd_data;
    s_ddr_addr = b_ddr_addr;
    s_ddr_data = b_ddr_data;
    if (sel) begin
      {s_cmd_ready, s_data_ready, s_rd_valid, s_ddr_wr, s_ddr_rd, s_busy, s_done, s_aborted} =
        {m_cmd_ready, m_data_ready, m_rd_valid, m_ddr_wr, m_ddr_rd, m_busy, m_done, m_aborted};
      s_rd_data  = m_rd_data;
      s_ddr_addr = m_ddr_addr;
      s_ddr_data = {448'b0, m_ddr_data};
    end
  end

  typedef struct {
    logic [26:0]  addr;
    logic [511:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [26:0] exp_rd[$];
  logic [7:0]  exp_byte[$];
  logic [7:0]  in_bytes[$];
  int          checks, failures, cyc, done_cnt, abort_cnt, done_cyc;
  bit          resp_en, wr_cont, rd_cont;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Contents of the simulated DDR: an arbitrary mix of address and lane.
  function automatic logic [7:0] mem_byte(input logic [26:0] wa, input int k);
    return (wa[7:0] ^ wa[15:8] ^ wa[23:16]) + 8'(k * 37) + {5'b0, wa[26:24]};
  endfunction

  function automatic int bpw_now();
    return sel ? 8 : 64;
  endfunction

  // Agent: DDR responder, byte source, read sink and output monitor.
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      i_ddr_wr_done = s_ddr_wr && resp_en && ($urandom % 2 == 1);
      i_ddr_rd_done = s_ddr_rd && resp_en && ($urandom % 2 == 1);
      for (int k = 0; k < 64; k++) i_ddr_rd_data[8*k +: 8] = mem_byte(s_ddr_addr, k);
      i_rd_ready    = ($urandom % 2 == 1);
      i_data_valid  = (in_bytes.size() != 0) && ($urandom % 4 != 0);
      i_data        = (in_bytes.size() != 0) ? in_bytes[0] : 8'h00;
      if (i_data_valid && s_data_ready) void'(in_bytes.pop_front());
      if (s_ddr_wr && !wr_cont) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected got_addr=%0h exp=none", s_ddr_addr);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 512'(s_ddr_addr), 512'(e.addr));
          chk("wr_data", s_ddr_data, e.data);
        end
      end
      wr_cont = s_ddr_wr && !i_ddr_wr_done;
      if (s_ddr_rd && !rd_cont) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected got_addr=%0h exp=none", s_ddr_addr);
        end else begin
          chk("rd_addr", 512'(s_ddr_addr), 512'(exp_rd.pop_front()));
        end
      end
      rd_cont = s_ddr_rd && !i_ddr_rd_done;
      if (s_rd_valid && i_rd_ready) begin
        if (exp_byte.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_byte_extra got=%0h exp=none", s_rd_data);
        end else begin
          chk("rd_byte", 512'(s_rd_data), 512'(exp_byte.pop_front()));
        end
      end
      if (s_done) begin done_cnt++; done_cyc = cyc; end
      if (s_aborted) abort_cnt++;
    end
  end

  task automatic flush();
    exp_wr.delete(); exp_rd.delete(); exp_byte.delete(); in_bytes.delete();
  endtask

  // Reference model: what a command must produce, from address/length rules.
  task automatic expect_cmd(input bit wr, input logic [26:0] addr, input int len);
    int bpw = bpw_now();
    logic [26:0] base;
    logic [7:0] b[$];
    base = addr & ~27'(bpw - 1);
    if (wr) begin
      for (int i = 0; i < len; i++) begin
        b.push_back(8'($urandom));
        in_bytes.push_back(b[i]);
      end
      for (int w = 0; w * bpw < len; w++) begin
        wr_t e;
        e.addr = base + 27'(w * bpw);
        e.data = '0;
        for (int k = 0; k < bpw; k++)
          if (w * bpw + k < len) e.data[8*k +: 8] = b[w * bpw + k];
        exp_wr.push_back(e);
      end
    end else begin
      for (int w = 0; w * bpw < len; w++) exp_rd.push_back(base + 27'(w * bpw));
      for (int i = 0; i < len; i++)
        exp_byte.push_back(mem_byte(base + 27'((i / bpw) * bpw), i % bpw));
    end
  endtask

  task automatic issue_cmd(input bit wr, input logic [26:0] addr, input int len,
                           output int acc, output bit ok);
    @(negedge i_clk); #2;
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_len = 20'(len);
    ok = 1'b0; acc = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (s_cmd_ready) begin ok = 1'b1; acc = cyc; end
      @(posedge i_clk); #1;
      if (!ok) begin @(negedge i_clk); #2; end
    end
    i_cmd_valid = 1'b0;
    chk("cmd_accept", 512'(ok), 512'(1));
  endtask

  task automatic run_cmd(input bit wr, input logic [26:0] addr, input int len);
    int acc, d0, a0;
    bit ok;
    expect_cmd(wr, addr, len);
    d0 = done_cnt; a0 = abort_cnt;
    issue_cmd(wr, addr, len, acc, ok);
    for (int t = 0; t < 20000 && ok && done_cnt == d0 && abort_cnt == a0; t++) begin
      @(negedge i_clk); #3;
    end
    if (len == 0) chk("len0_latency", 512'((done_cyc - acc) >= 1 && (done_cyc - acc) <= 2), 512'(1));
    repeat (3) begin @(negedge i_clk); #3; end
    chk("done_once", 512'(done_cnt - d0), 512'(1));
    chk("no_abort", 512'(abort_cnt - a0), 512'(0));
    chk("wr_left", 512'(exp_wr.size()), 512'(0));
    chk("rd_left", 512'(exp_rd.size()), 512'(0));
    chk("byte_left", 512'(exp_byte.size() + in_bytes.size()), 512'(0));
    flush();
  endtask

  task automatic do_reset();
    @(negedge i_clk); #2;
    reset = 1'b1;
    repeat (3) @(negedge i_clk);
    #2 reset = 1'b0;
    flush();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, d0, a0;
    bit ok;
    checks = 0; failures = 0; cyc = 0; done_cnt = 0; abort_cnt = 0; done_cyc = 0;
    resp_en = 1'b1; wr_cont = 1'b0; rd_cont = 1'b0; sel = 1'b0;
    reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_abort = 1'b0;
    i_data = '0; i_data_valid = 1'b0; i_rd_ready = 1'b0; i_ddr_wr_done = 1'b0; i_ddr_rd_done = 1'b0;
    i_ddr_rd_data = '0;

    repeat (3) @(negedge i_clk);
    #2;
    chk("reset_ctrl", 512'({s_cmd_ready, s_busy, s_ddr_wr, s_ddr_rd, s_rd_valid, s_data_ready, s_done, s_aborted}), 512'(0));
    chk("reset_addr", 512'(s_ddr_addr), 512'(0));
    chk("reset_data", s_ddr_data, 512'(0));
    reset = 1'b0;
    @(negedge i_clk); #2;
    chk("idle_ready", 512'(s_cmd_ready), 512'(1));

    run_cmd(1'b1, 27'h40, 128);
    run_cmd(1'b1, 27'h100, 70);
    run_cmd(1'b0, 27'h1000, 65);
    run_cmd(1'b1, 27'h200, 0);
    run_cmd(1'b0, 27'h240, 0);
    for (int i = 0; i < 10; i++)
      run_cmd(1'($urandom), 27'($urandom), int'($urandom_range(200, 1)));

    // Abort coinciding with a write done.
    resp_en = 1'b0;
    expect_cmd(1'b1, 27'h2000, 128);
    issue_cmd(1'b1, 27'h2000, 128, acc, ok);
    for (int t = 0; t < 2000 && !s_ddr_wr; t++) begin @(negedge i_clk); #2; end
    chk("abort_wr_reached", 512'(s_ddr_wr), 512'(1));
    d0 = done_cnt;
    i_abort = 1'b1; i_ddr_wr_done = 1'b1;
    @(posedge i_clk); #1;
    chk("abort_wr_low", 512'(s_ddr_wr), 512'(0));
    chk("abort_pulse", 512'(s_aborted), 512'(1));
    chk("abort_no_done", 512'(s_done), 512'(0));
    i_abort = 1'b0; i_ddr_wr_done = 1'b0; resp_en = 1'b1;
    flush();
    repeat (2) @(negedge i_clk);
    chk("abort_no_done_cnt", 512'(done_cnt - d0), 512'(0));
    run_cmd(1'b1, 27'h2000, 64);

    // Switch to the 64-bit instance; reset in the middle of a drain.
    sel = 1'b1;
    do_reset();
    expect_cmd(1'b0, 27'h300, 16);
    issue_cmd(1'b0, 27'h300, 16, acc, ok);
    for (int t = 0; t < 2000 && !s_rd_valid; t++) begin @(negedge i_clk); #2; end
    chk("drain_reached", 512'(s_rd_valid), 512'(1));
    reset = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_ctrl", 512'({s_cmd_ready, s_busy, s_ddr_wr, s_ddr_rd, s_rd_valid, s_data_ready, s_done, s_aborted}), 512'(0));
    chk("rst_addr", 512'(s_ddr_addr), 512'(0));
    d0 = done_cnt; a0 = abort_cnt;
    repeat (2) @(negedge i_clk);
    #2 reset = 1'b0;
    flush();
    repeat (3) begin @(negedge i_clk); #3; end
    chk("rst_no_pulse", 512'((done_cnt - d0) + (abort_cnt - a0)), 512'(0));
    run_cmd(1'b0, 27'h2000, 8);
    run_cmd(1'b0, 27'h7FFFFF8, 16);
    run_cmd(1'b1, 27'h7FFFFF8, 16);
    for (int i = 0; i < 6; i++)
      run_cmd(1'($urandom), 27'($urandom), int'($urandom_range(40, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
